// File: rtl/rv_pkg.sv
// Shared register-file constants and the writeback FIFO entry layout.
package rv_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

  typedef struct packed {
    logic                  kill;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_P    = 2'd1,
    GNT_S    = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_fifo.sv
// Secondary writeback FIFO with per-entry kill flag, kill-by-rd squash and
// a one-hot OR of live destination registers.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic [REG_ADDR_W-1:0] push_rd_i,
  input  logic [XLEN-1:0]       push_data_i,
  input  logic                  pop_i,
  input  logic                  kill_en_i,
  input  logic [REG_ADDR_W-1:0] kill_rd_i,
  output logic                  empty_o,
  output logic                  full_o,
  output wb_entry_t             head_o,
  output logic [NUM_REGS-1:0]   busy_mask_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        entries_q [DEPTH];
  wb_entry_t        entries_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] live_c;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign head_o  = entries_q[rd_ptr_q];

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] off;
    live_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off       = PTR_W'(i) - rd_ptr_q;
      live_c[i] = (CNT_W'(off) < cnt_q);
    end
  end

  always_comb begin
    busy_mask_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_c[i] && !entries_q[i].kill) busy_mask_o[entries_q[i].rd] = 1'b1;
    end
    busy_mask_o[0] = 1'b0;
  end

  // Squash is applied before the push so the incoming (younger) entry survives.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (kill_en_i && live_c[i] && entries_q[i].rd == kill_rd_i) entries_d[i].kill = 1'b1;
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      entries_d[wr_ptr_q] = '{kill: 1'b0, rd: push_rd_i, data: push_data_i};
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (pop_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: in-order WB stage has priority, the
// buffered long-latency source is forced through after STARVE_MAX losses.
module rf_wb_arbiter
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  p_wen,
  input  logic [REG_ADDR_W-1:0] p_rd,
  input  logic [XLEN-1:0]       p_data,
  input  logic                  s_valid,
  input  logic [REG_ADDR_W-1:0] s_rd,
  input  logic [XLEN-1:0]       s_data,
  output logic                  s_ready,
  output logic                  rf_wen,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic [XLEN-1:0]       rf_data,
  output logic                  stall_o,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  fifo_full
);

  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  logic                  rf_wen_q, rf_wen_d;
  logic [REG_ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [XLEN-1:0]       rf_data_q, rf_data_d;
  logic [STV_W-1:0]      starve_q, starve_d;

  grant_e    grant_c;
  logic      fifo_empty;
  logic      starved_c;
  logic      push_c;
  wb_entry_t head;

  assign starved_c = (starve_q == STV_W'(STARVE_MAX));
  assign s_ready   = ~fifo_full & reset_n;
  assign push_c    = s_valid & s_ready & (s_rd != X0);
  assign stall_o   = starved_c & ~fifo_empty;
  assign rf_wen    = rf_wen_q;
  assign rf_addr   = rf_addr_q;
  assign rf_data   = rf_data_q;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push_c),
    .push_rd_i   (s_rd),
    .push_data_i (s_data),
    .pop_i       (grant_c == GNT_S),
    .kill_en_i   ((grant_c == GNT_P) && (p_rd != X0)),
    .kill_rd_i   (p_rd),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .head_o      (head),
    .busy_mask_o (busy_mask)
  );

  always_comb begin
    grant_c = GNT_IDLE;
    if (!fifo_empty && (!p_wen || starved_c)) grant_c = GNT_S;
    else if (p_wen)                           grant_c = GNT_P;
  end

  // Write-port and starvation-counter next state; a killed head wastes its slot.
  always_comb begin
    rf_wen_d  = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    starve_d  = starve_q;
    unique case (grant_c)
      GNT_P: begin
        rf_wen_d  = (p_rd != X0);
        rf_addr_d = p_rd;
        rf_data_d = p_data;
        if (!fifo_empty && !starved_c) starve_d = starve_q + STV_W'(1);
      end
      GNT_S: begin
        rf_wen_d  = ~head.kill;
        rf_addr_d = head.rd;
        rf_data_d = head.data;
        starve_d  = '0;
      end
      default: ;
    endcase
    if (fifo_empty) starve_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rf_wen_q  <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      starve_q  <= '0;
    end else begin
      rf_wen_q  <= rf_wen_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      starve_q  <= starve_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with hand-computed expectations.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        reset_n;
  logic        p_wen;
  logic [4:0]  p_rd;
  logic [31:0] p_data;
  logic        s_valid;
  logic [4:0]  s_rd;
  logic [31:0] s_data;
  logic        s_ready;
  logic        rf_wen;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        stall_o;
  logic [31:0] busy_mask;
  logic        fifo_full;

  int vectors = 0;
  int errors  = 0;

  rf_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .p_wen     (p_wen),
    .p_rd      (p_rd),
    .p_data    (p_data),
    .s_valid   (s_valid),
    .s_rd      (s_rd),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .rf_wen    (rf_wen),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .stall_o   (stall_o),
    .busy_mask (busy_mask),
    .fifo_full (fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with both sources requesting
    reset_n = 1'b0; p_wen = 1'b1; p_rd = 5'd1; p_data = 32'h11;
    s_valid = 1'b1; s_rd = 5'd2; s_data = 32'h22;
    tick();
    chk("rst1_wen",   32'(rf_wen), 32'd0);
    chk("rst1_rdy",   32'(s_ready), 32'd0);
    chk("rst1_busy",  busy_mask, 32'd0);
    chk("rst1_addr",  32'(rf_addr), 32'd0);
    chk("rst1_data",  rf_data, 32'd0);
    chk("rst1_full",  32'(fifo_full), 32'd0);
    chk("rst1_stall", 32'(stall_o), 32'd0);
    tick();
    chk("rst2_wen",  32'(rf_wen), 32'd0);
    chk("rst2_rdy",  32'(s_ready), 32'd0);
    chk("rst2_busy", busy_mask, 32'd0);
    reset_n = 1'b1; p_wen = 1'b0; s_valid = 1'b0;
    #1;
    chk("rel_rdy", 32'(s_ready), 32'd1);

    // Primary only
    p_wen = 1'b1; p_rd = 5'd5; p_data = 32'hDEADBEEF;
    tick();
    chk("p_wen",  32'(rf_wen), 32'd1);
    chk("p_addr", 32'(rf_addr), 32'd5);
    chk("p_data", rf_data, 32'hDEADBEEF);
    p_rd = 5'd0; p_data = 32'h55;
    tick();
    chk("p_x0_wen", 32'(rf_wen), 32'd0);

    // Secondary through an idle write port
    p_wen = 1'b0; s_valid = 1'b1; s_rd = 5'd7; s_data = 32'h1234;
    #1;
    chk("s_rdy", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    chk("s_busy1", busy_mask, 32'h0000_0080);
    chk("s_wen1",  32'(rf_wen), 32'd0);
    tick();
    chk("s_wen2",  32'(rf_wen), 32'd1);
    chk("s_addr2", 32'(rf_addr), 32'd7);
    chk("s_data2", rf_data, 32'h1234);
    chk("s_busy2", busy_mask, 32'd0);

    // Starvation: fill with rd3, rd4 while primary streams
    p_wen = 1'b1; p_rd = 5'd10; p_data = 32'd100;
    s_valid = 1'b1; s_rd = 5'd3; s_data = 32'h33;
    tick();
    chk("st_addr10", 32'(rf_addr), 32'd10);
    chk("st_wen10",  32'(rf_wen), 32'd1);
    p_rd = 5'd11; p_data = 32'd101; s_rd = 5'd4; s_data = 32'h44;
    tick();
    chk("st_addr11", 32'(rf_addr), 32'd11);
    chk("st_full",   32'(fifo_full), 32'd1);
    chk("st_busy",   busy_mask, 32'h0000_0018);
    s_rd = 5'd5; s_data = 32'h55;
    #1;
    chk("st_rdy_full", 32'(s_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      p_rd = 5'(12 + k); p_data = 32'(112 + k);
      #1;
      chk("st_nostall_a", 32'(stall_o), 32'd0);
      tick();
      s_valid = 1'b0;
      chk("st_addr_a", 32'(rf_addr), 32'(12 + k));
    end
    chk("st_busy_kept", busy_mask, 32'h0000_0018);
    p_rd = 5'd15; p_data = 32'd115;
    #1;
    chk("st_stall1", 32'(stall_o), 32'd1);
    tick();
    chk("st_pop3_addr", 32'(rf_addr), 32'd3);
    chk("st_pop3_data", rf_data, 32'h33);
    chk("st_pop3_wen",  32'(rf_wen), 32'd1);
    chk("st_pop3_busy", busy_mask, 32'h0000_0010);
    chk("st_pop3_full", 32'(fifo_full), 32'd0);
    #1;
    chk("st_nostall_h", 32'(stall_o), 32'd0);
    tick();
    chk("st_held_addr", 32'(rf_addr), 32'd15);
    chk("st_held_data", rf_data, 32'd115);
    for (int k = 0; k < 3; k++) begin
      p_rd = 5'(16 + k); p_data = 32'(116 + k);
      #1;
      chk("st_nostall_b", 32'(stall_o), 32'd0);
      tick();
      chk("st_addr_b", 32'(rf_addr), 32'(16 + k));
    end
    p_rd = 5'd19; p_data = 32'd119;
    #1;
    chk("st_stall2", 32'(stall_o), 32'd1);
    tick();
    chk("st_pop4_addr", 32'(rf_addr), 32'd4);
    chk("st_pop4_data", rf_data, 32'h44);
    chk("st_pop4_busy", busy_mask, 32'd0);
    #1;
    chk("st_nostall_e", 32'(stall_o), 32'd0);
    tick();
    chk("st_addr19", 32'(rf_addr), 32'd19);

    // WAW squash of an older FIFO entry
    p_wen = 1'b0; s_valid = 1'b1; s_rd = 5'd9; s_data = 32'h99;
    tick();
    s_valid = 1'b0;
    chk("waw_wen0", 32'(rf_wen), 32'd0);
    chk("waw_busy", busy_mask, 32'h0000_0200);
    p_wen = 1'b1; p_rd = 5'd9; p_data = 32'hA;
    tick();
    chk("waw_wen",    32'(rf_wen), 32'd1);
    chk("waw_addr",   32'(rf_addr), 32'd9);
    chk("waw_data",   rf_data, 32'hA);
    chk("waw_killed", busy_mask, 32'd0);
    p_wen = 1'b0;
    tick();
    chk("waw_pop_wen", 32'(rf_wen), 32'd0);
    tick();
    chk("waw_idle_wen", 32'(rf_wen), 32'd0);

    // Same-cycle push is younger than the primary write and survives
    p_wen = 1'b1; p_rd = 5'd9; p_data = 32'hB;
    s_valid = 1'b1; s_rd = 5'd9; s_data = 32'h77;
    tick();
    p_wen = 1'b0; s_valid = 1'b0;
    chk("yng_addr", 32'(rf_addr), 32'd9);
    chk("yng_data", rf_data, 32'hB);
    chk("yng_busy", busy_mask, 32'h0000_0200);
    tick();
    chk("yng_pop_wen",  32'(rf_wen), 32'd1);
    chk("yng_pop_data", rf_data, 32'h77);
    chk("yng_pop_busy", busy_mask, 32'd0);

    // x0 secondary write is accepted and dropped
    s_valid = 1'b1; s_rd = 5'd0; s_data = 32'hEE;
    #1;
    chk("x0_rdy", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    chk("x0_busy", busy_mask, 32'd0);
    chk("x0_wen1", 32'(rf_wen), 32'd0);
    tick();
    chk("x0_wen2", 32'(rf_wen), 32'd0);
    chk("x0_full", 32'(fifo_full), 32'd0);

    // Reset with a pending entry discards it
    s_valid = 1'b1; s_rd = 5'd6; s_data = 32'h66;
    tick();
    s_valid = 1'b0;
    chk("mrst_busy0", busy_mask, 32'h0000_0040);
    reset_n = 1'b0;
    tick();
    chk("mrst_wen",  32'(rf_wen), 32'd0);
    chk("mrst_busy", busy_mask, 32'd0);
    chk("mrst_rdy",  32'(s_ready), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("mrst_after_wen",  32'(rf_wen), 32'd0);
    chk("mrst_after_busy", busy_mask, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Arbitrates the single register-file write port between two writeback sources.
  - Primary: in-order pipeline WB stage, one write per cycle, high priority.
  - Secondary: long-latency unit (load miss / mul-div), valid/ready handshake, buffered in a small FIFO.
- Sits between the WB stage and the register file; drives rf_wen/rf_addr/rf_data.
- Exports a pending-write mask to the hazard unit and a stall to the pipeline when the secondary source is starved.

Parameters:
- DEPTH, 2, secondary FIFO entries (power of 2, >=2).
- STARVE_MAX, 4, consecutive primary grants tolerated while the FIFO is non-empty before a forced secondary grant.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  reset, synchronous, active-low.
- p_wen  in  1  primary write request.
- p_rd  in  5  primary destination register.
- p_data  in  32  primary write data.
- s_valid  in  1  secondary write request valid.
- s_rd  in  5  secondary destination register.
- s_data  in  32  secondary write data.
- s_ready  out  1  secondary accept: ~fifo_full and reset_n.
- rf_wen  out  1  register-file write enable (registered).
- rf_addr  out  5  register-file write address (registered).
- rf_data  out  32  register-file write data (registered).
- stall_o  out  1  combinational: starve_cnt==STARVE_MAX and FIFO non-empty.
- busy_mask  out  32  bit r set when a live (non-killed) FIFO entry targets r; bit 0 always 0.
- fifo_full  out  1  FIFO holds DEPTH entries.

Behaviour:
- Reset (reset_n low at posedge):
  - rf_wen=0, rf_addr=0, rf_data=0.
  - FIFO empty, all kill flags clear, starve_cnt=0.
  - busy_mask=0, fifo_full=0, stall_o=0; s_ready=0 while reset_n low.
  - Reset mid-operation discards all pending entries with no write issued.
- Grant decision each cycle, evaluated on current inputs/state:
  - G_S if FIFO non-empty and (p_wen=0 or starve_cnt==STARVE_MAX).
  - Else G_P if p_wen=1.
  - Else idle.
- Primary accepted (G_P):
  - Latch rf_wen=(p_rd!=0), rf_addr=p_rd, rf_data=p_data at posedge.
  - The register file writes on the following negedge, so write latency is 1 cycle.
- Forced G_S with p_wen=1:
  - stall_o=1; the primary request is NOT consumed.
  - The pipeline holds p_wen/p_rd/p_data stable into the next cycle.
- Secondary grant (G_S):
  - Pop the FIFO head.
  - If the head is not killed: rf_wen=1 with the head's rd/data.
  - If the head is killed: rf_wen=0 (slot wasted, still counts as a pop).
- Secondary enqueue on s_valid and s_ready:
  - s_rd==0: accepted and discarded (not enqueued).
  - Otherwise pushed at the tail with kill=0.
  - Push and pop in the same cycle are both allowed.
  - s_ready does not look ahead at the pop: full means not ready even when popping.
  - Minimum secondary latency: accept at cycle N, earliest rf_wen high at cycle N+2.
- WAW squash:
  - On a G_P with p_rd!=0, every live FIFO entry whose rd==p_rd gets kill=1 at the same posedge.
  - A same-cycle incoming secondary push is younger, so it is not killed.
- starve_cnt:
  - Increments on G_P while the FIFO is non-empty, saturating at STARVE_MAX.
  - Clears on any pop and whenever the FIFO is empty.
- busy_mask:
  - Recomputed from the live entries each cycle.
  - Duplicate rds OR together.
  - Killed entries do not contribute.
- Pointers: wrap modulo DEPTH; occupancy counter width is clog2(DEPTH)+1.

Decomposition:
- Shared package rv_pkg: REG_ADDR_W=5, XLEN=32, NUM_REGS=32, X0=5'd0.
- One sub-module: wb_fifo.
  - Parameterised DEPTH, per-entry {kill, rd, data}.
  - Provides a kill-by-rd input and a live-entry rd one-hot OR output.
- The arbiter FSM/counter stays in the top level.

Test Plan:
- Reset: hold reset_n=0 two cycles with p_wen=1 and s_valid=1.
  - Expect rf_wen=0, s_ready=0, busy_mask=0 throughout.
  - First cycle after release: s_ready=1.
- Primary only: p_wen=1, p_rd=5, p_data=32'hDEADBEEF at cycle N.
  - Expect rf_wen=1, rf_addr=5, rf_data=32'hDEADBEEF at N+1.
  - Then p_rd=0 -> rf_wen=0.
- Secondary idle path: s_valid=1, s_rd=7, s_data=32'h1234, p_wen=0, at N.
  - Expect busy_mask[7]=1 at N+1 and rf_wen=1, rf_addr=7 at N+2.
  - Expect busy_mask[7]=0 after the pop.
- Starvation: fill FIFO (2 entries, rd=3 and rd=4), hold p_wen=1 continuously.
  - Expect 4 primary grants, then stall_o=1 and rf_addr=3.
  - starve_cnt clears, then 4 more primary grants before rf_addr=4.
  - s_ready=0 while full.
- WAW squash: enqueue s_rd=9, then p_wen=1, p_rd=9, data=32'hA at the next cycle.
  - Expect rf_addr=9, rf_data=32'hA and busy_mask[9]=0.
  - The later FIFO pop produces rf_wen=0.
- x0 filter: s_valid=1, s_rd=0 -> s_ready=1, FIFO occupancy unchanged, no rf_wen ever asserted.
